// File: rtl/frame_loader_bram.sv
// Captures one video frame from a valid/ready pixel stream into BRAM0 and then
// holds the buffer until the downstream consumer signals that it is finished.
module frame_loader_bram #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 16,
  parameter int IMAGE_WIDTH  = 279,
  parameter int IMAGE_HEIGHT = 210,
  parameter int IMAGE_SIZE   = IMAGE_WIDTH * IMAGE_HEIGHT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic                  i_consumer_done,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_sof,
  input  logic                  s_eol,
  output logic [DATA_WIDTH-1:0] b0_d0,
  output logic                  b0_ce0,
  output logic                  b0_we0,
  output logic [ADDR_WIDTH-1:0] b0_addr0,
  output logic                  o_complete,
  output logic [ADDR_WIDTH-1:0] o_num_cnt,
  output logic                  o_busy,
  output logic                  o_err
);

  localparam int COL_W = $clog2(IMAGE_WIDTH + 1);
  localparam int ROW_W = $clog2(IMAGE_HEIGHT + 2);
  localparam logic [COL_W-1:0]      COL_LAST  = COL_W'(IMAGE_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(IMAGE_SIZE - 1);

  typedef enum logic [2:0] {IDLE, SYNC, LOAD, CMPL, HOLD} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_cnt_q, addr_cnt_d;
  logic [COL_W-1:0]        col_q, col_d;
  logic [ROW_W-1:0]        row_q, row_d;
  logic [ADDR_WIDTH-1:0]   num_cnt_q, num_cnt_d;
  logic                    err_q, err_d;

  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [COL_W-1:0]        pix_col;
  logic [ROW_W-1:0]        pix_row;

  always_comb begin
    state_d    = state_q;
    addr_cnt_d = addr_cnt_q;
    col_d      = col_q;
    row_d      = row_q;
    num_cnt_d  = num_cnt_q;
    err_d      = err_q;
    s_ready    = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = addr_cnt_q;
    pix_col    = col_q;
    pix_row    = row_q;

    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d    = SYNC;
          addr_cnt_d = '0;
          col_d      = '0;
          row_d      = '0;
          num_cnt_d  = '0;
          err_d      = 1'b0;
        end
      end
      SYNC: begin
        s_ready = 1'b1;
        if (s_valid && s_sof) begin
          wr_en   = 1'b1;
          wr_addr = '0;
          pix_col = '0;
          pix_row = '0;
        end
      end
      LOAD: begin
        s_ready = 1'b1;
        if (s_valid) begin
          wr_en = 1'b1;
          // A fresh sof mid-frame restarts the frame at address 0.
          if (s_sof) begin
            err_d   = 1'b1;
            wr_addr = '0;
            pix_col = '0;
            pix_row = '0;
          end
        end
      end
      CMPL: state_d = HOLD;
      HOLD: begin
        if (i_consumer_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (wr_en) begin
      if (s_eol != (pix_col == COL_LAST)) err_d = 1'b1;
      if (pix_col == COL_LAST) begin
        col_d = '0;
        row_d = pix_row + ROW_W'(1);
      end else begin
        col_d = pix_col + COL_W'(1);
        row_d = pix_row;
      end
      num_cnt_d = wr_addr + ADDR_WIDTH'(1);
      if (wr_addr == ADDR_LAST) begin
        state_d    = CMPL;
        addr_cnt_d = '0;
      end else begin
        state_d    = LOAD;
        addr_cnt_d = wr_addr + ADDR_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_cnt_q <= '0;
      col_q      <= '0;
      row_q      <= '0;
      num_cnt_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_cnt_q <= addr_cnt_d;
      col_q      <= col_d;
      row_q      <= row_d;
      num_cnt_q  <= num_cnt_d;
      err_q      <= err_d;
    end
  end

  // Data and address are zeroed when idle so the write port is quiet outside transfers.
  assign b0_ce0     = wr_en;
  assign b0_we0     = wr_en;
  assign b0_d0      = wr_en ? s_data : '0;
  assign b0_addr0   = wr_en ? wr_addr : '0;
  assign o_complete = (state_q == CMPL);
  assign o_busy     = (state_q != IDLE);
  assign o_err      = err_q;
  assign o_num_cnt  = num_cnt_q;

endmodule

// File: tb/tb_frame_loader_bram.sv
// Directed bench for frame_loader_bram on a reduced 8x4 image; BRAM writes are
// matched against a queue of expected (address, data) pairs.
module tb_frame_loader_bram;
  localparam int DW = 8;
  localparam int AW = 8;
  localparam int W  = 8;
  localparam int H  = 4;
  localparam int SZ = W * H;

  logic          clk = 1'b0;
  logic          rst_n, i_start, i_consumer_done;
  logic          s_valid, s_ready, s_sof, s_eol;
  logic [DW-1:0] s_data;
  logic [DW-1:0] b0_d0;
  logic          b0_ce0, b0_we0;
  logic [AW-1:0] b0_addr0;
  logic          o_complete, o_busy, o_err;
  logic [AW-1:0] o_num_cnt;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  frame_loader_bram #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .IMAGE_SIZE(SZ)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_consumer_done(i_consumer_done),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_sof(s_sof), .s_eol(s_eol),
    .b0_d0(b0_d0), .b0_ce0(b0_ce0), .b0_we0(b0_we0), .b0_addr0(b0_addr0),
    .o_complete(o_complete), .o_num_cnt(o_num_cnt), .o_busy(o_busy), .o_err(o_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Every BRAM write must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (b0_we0 === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {31'b0, b0_we0}, 32'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", {24'b0, b0_addr0}, {24'b0, e.addr});
        check("wr_data", {24'b0, b0_d0}, {24'b0, e.data});
        check("wr_ce", {31'b0, b0_ce0}, 32'd1);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pix(input logic [DW-1:0] d, input logic sof, input logic eol,
                          input bit expect_wr, input int addr);
    wr_t e;
    s_valid = 1'b1;
    s_data  = d;
    s_sof   = sof;
    s_eol   = eol;
    if (expect_wr) begin
      e.addr = AW'(addr);
      e.data = d;
      exp_q.push_back(e);
    end
    @(negedge clk);
    check("s_ready", {31'b0, s_ready}, 32'd1);
    next_cycle();
    s_valid = 1'b0;
    s_sof   = 1'b0;
    s_eol   = 1'b0;
  endtask

  task automatic start_frame();
    i_start = 1'b1;
    next_cycle();
    i_start = 1'b0;
    @(negedge clk);
    check("start_busy", {31'b0, o_busy}, 32'd1);
    check("start_err", {31'b0, o_err}, 32'd0);
    check("start_num", {24'b0, o_num_cnt}, 32'd0);
    next_cycle();
  endtask

  task automatic send_frame(input bit gaps, input int bad_line);
    for (int i = 0; i < SZ; i++) begin
      logic eol;
      if (gaps && $urandom_range(0, 2) == 0) begin
        s_data = DW'($urandom);
        repeat ($urandom_range(1, 2)) next_cycle();
      end
      eol = ((i % W) == W - 1);
      if ((i / W) == bad_line && (i % W) == 3) eol = 1'b1;
      send_pix(DW'($urandom), i == 0, eol, 1'b1, i);
    end
  endtask

  task automatic expect_complete(input logic exp_err);
    @(negedge clk);
    check("cmpl_pulse", {31'b0, o_complete}, 32'd1);
    check("cmpl_num", {24'b0, o_num_cnt}, SZ);
    check("cmpl_err", {31'b0, o_err}, {31'b0, exp_err});
    next_cycle();
    @(negedge clk);
    check("cmpl_one_cycle", {31'b0, o_complete}, 32'd0);
    check("hold_busy", {31'b0, o_busy}, 32'd1);
    check("hold_err", {31'b0, o_err}, {31'b0, exp_err});
    check("queue_empty", exp_q.size(), 32'd0);
    next_cycle();
  endtask

  task automatic release_hold();
    i_consumer_done = 1'b1;
    next_cycle();
    i_consumer_done = 1'b0;
    @(negedge clk);
    check("release_busy", {31'b0, o_busy}, 32'd0);
    check("idle_num_held", {24'b0, o_num_cnt}, SZ);
    next_cycle();
  endtask

  initial begin
    rst_n = 1'b0; i_start = 1'b0; i_consumer_done = 1'b0;
    s_valid = 1'b1; s_data = 8'hA5; s_sof = 1'b1; s_eol = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'b0, s_ready}, 32'd0);
    check("rst_we", {31'b0, b0_we0}, 32'd0);
    check("rst_ce", {31'b0, b0_ce0}, 32'd0);
    check("rst_d0", {24'b0, b0_d0}, 32'd0);
    check("rst_addr", {24'b0, b0_addr0}, 32'd0);
    check("rst_cmpl", {31'b0, o_complete}, 32'd0);
    check("rst_busy", {31'b0, o_busy}, 32'd0);
    check("rst_err", {31'b0, o_err}, 32'd0);
    check("rst_num", {24'b0, o_num_cnt}, 32'd0);
    rst_n = 1'b1; s_valid = 1'b0; s_sof = 1'b0;
    next_cycle();

    // Nominal frame
    start_frame();
    send_frame(1'b0, -1);
    expect_complete(1'b0);

    // Hold: traffic and i_start are ignored until the consumer releases
    for (int k = 0; k < 20; k++) begin
      s_valid = 1'b1; s_data = DW'($urandom); s_sof = (k == 0);
      i_start = (k == 10);
      @(negedge clk);
      check("hold_ready", {31'b0, s_ready}, 32'd0);
      check("hold_busy_k", {31'b0, o_busy}, 32'd1);
      next_cycle();
    end
    s_valid = 1'b0; s_sof = 1'b0; i_start = 1'b0;
    release_hold();

    // Junk before sof, then a frame with random backpressure gaps
    start_frame();
    for (int j = 0; j < 10; j++) send_pix(DW'($urandom), 1'b0, 1'b0, 1'b0, 0);
    send_frame(1'b1, -1);
    expect_complete(1'b0);
    release_hold();

    // Bad line: early eol in line 2
    start_frame();
    send_frame(1'b0, 2);
    expect_complete(1'b1);
    release_hold();
    @(negedge clk);
    check("idle_err_sticky", {31'b0, o_err}, 32'd1);
    next_cycle();
    start_frame();

    // Frame restart: sof after five pixels
    for (int i = 0; i < 5; i++) send_pix(DW'($urandom), i == 0, 1'b0, 1'b1, i);
    send_pix(DW'($urandom), 1'b1, 1'b0, 1'b1, 0);
    @(negedge clk);
    check("restart_err", {31'b0, o_err}, 32'd1);
    next_cycle();
    for (int i = 1; i < SZ; i++) send_pix(DW'($urandom), 1'b0, (i % W) == W - 1, 1'b1, i);
    expect_complete(1'b1);
    release_hold();

    // Mid-frame reset: the pixel presented during the reset cycle is still written
    start_frame();
    for (int i = 0; i < 10; i++) send_pix(DW'($urandom), i == 0, (i % W) == W - 1, 1'b1, i);
    begin
      wr_t e;
      s_valid = 1'b1; s_data = 8'h3C; rst_n = 1'b0;
      e.addr = AW'(10); e.data = 8'h3C;
      exp_q.push_back(e);
      next_cycle();
    end
    rst_n = 1'b1; s_data = 8'h5A;
    @(negedge clk);
    check("mrst_ready", {31'b0, s_ready}, 32'd0);
    check("mrst_we", {31'b0, b0_we0}, 32'd0);
    check("mrst_d0", {24'b0, b0_d0}, 32'd0);
    check("mrst_addr", {24'b0, b0_addr0}, 32'd0);
    check("mrst_busy", {31'b0, o_busy}, 32'd0);
    check("mrst_num", {24'b0, o_num_cnt}, 32'd0);
    check("mrst_queue", exp_q.size(), 32'd0);
    repeat (3) next_cycle();
    s_valid = 1'b0;
    start_frame();
    send_frame(1'b1, -1);
    expect_complete(1'b0);
    release_hold();

    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
